// File: rtl/issue_hazard_ctrl.sv
// Scoreboard issue controller for the dual-lane integer pipeline. It keeps one latency countdown
// per GPR and holds the decode bundle on RAW/WAW hazards or on an external hold.
module issue_hazard_ctrl #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue_valid,
    input  logic [4:0]       u_rs_a,
    input  logic [4:0]       u_rs_b,
    input  logic [4:0]       l_rs_a,
    input  logic [4:0]       l_rs_b,
    input  logic             u_rs_a_use,
    input  logic             u_rs_b_use,
    input  logic             l_rs_a_use,
    input  logic             l_rs_b_use,
    input  logic [4:0]       u_rt,
    input  logic [4:0]       l_rt,
    input  logic             u_rt_flag,
    input  logic             l_rt_flag,
    input  logic [LAT_W-1:0] u_lat,
    input  logic [LAT_W-1:0] l_lat,
    input  logic             hold,
    output logic             stall,
    output logic             pair_conflict,
    output logic [5:0]       pending,
    output logic [31:0]      stall_cnt
);

    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic [5:0]       pending_d;
    logic [NREG-1:0]  ld_u;
    logic [NREG-1:0]  ld_l;
    logic             src_busy;
    logic             u_waw;
    logic             l_waw;
    logic             hazard;
    logic             accept;
    logic [LAT_W-1:0] max_lat;

    assign src_busy = (u_rs_a_use && (cnt_q[u_rs_a] != '0)) ||
                      (u_rs_b_use && (cnt_q[u_rs_b] != '0)) ||
                      (l_rs_a_use && (cnt_q[l_rs_a] != '0)) ||
                      (l_rs_b_use && (cnt_q[l_rs_b] != '0));

    // An older write still outstanding past the new one's latency would land last.
    assign u_waw = u_rt_flag && (cnt_q[u_rt] > u_lat);
    assign l_waw = l_rt_flag && (cnt_q[l_rt] > l_lat);

    assign hazard = issue_valid && (src_busy || u_waw || l_waw);
    assign stall  = hold || hazard;
    assign accept = issue_valid && !stall;

    assign pair_conflict = issue_valid &&
                           ((l_rs_a_use && u_rt_flag && (l_rs_a == u_rt)) ||
                            (l_rs_b_use && u_rt_flag && (l_rs_b == u_rt)) ||
                            (u_rt_flag && l_rt_flag && (u_rt == l_rt)));

    assign max_lat = (u_lat > l_lat) ? u_lat : l_lat;

    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NREG; i++) begin
            ld_u[i]  = accept && u_rt_flag && (u_rt == 5'(i));
            ld_l[i]  = accept && l_rt_flag && (l_rt == 5'(i));
            cnt_d[i] = cnt_q[i];
            if (!hold && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - LAT_W'(1);
            end
            // accept implies !hold, so loads never fight the freeze
            if (ld_u[i] && ld_l[i]) begin
                cnt_d[i] = max_lat;
            end else if (ld_u[i]) begin
                cnt_d[i] = u_lat;
            end else if (ld_l[i]) begin
                cnt_d[i] = l_lat;
            end
            pending_d = pending_d + 6'(cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '{default: '0};
            pending   <= '0;
            stall_cnt <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pending <= pending_d;
            if (hazard && !hold && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule
